// File: rtl/result_word_serializer_if.sv
// Row-capture and uart_tx handshake bundle for result_word_serializer.
// master: the serializer; slave: the row source and UART side.
interface result_word_serializer_if #(
    parameter int COL    = 4,
    parameter int W_WORD = 32,
    parameter int W_DATA = 8
);
    logic                  i_load;
    logic [COL*W_WORD-1:0] i_words;
    logic                  o_tx_dv;
    logic [W_DATA-1:0]     o_tx_byte;
    logic                  i_tx_done;
    logic                  o_full;
    logic                  o_busy;
    logic                  o_overflow;

    modport master (
        input  i_load, i_words, i_tx_done,
        output o_tx_dv, o_tx_byte, o_full, o_busy, o_overflow
    );

    modport slave (
        output i_load, i_words, i_tx_done,
        input  o_tx_dv, o_tx_byte, o_full, o_busy, o_overflow
    );
endinterface

// File: rtl/result_word_serializer.sv
// Buffers result rows in a small FIFO and drains them byte-wise into uart_tx.
// Optional RESULT_SER_FRAME_HEADER_EN prefixes each row with 0xA5 and a sequence byte.
module result_word_serializer #(
    parameter int COL    = 4,
    parameter int W_WORD = 32,
    parameter int W_DATA = 8,
    parameter int DEPTH  = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    result_word_serializer_if.master bus
);
    localparam int RW    = COL * W_WORD;
    localparam int BYTES = RW / W_DATA;
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int IW    = (BYTES > 1) ? $clog2(BYTES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        WAIT
`ifdef RESULT_SER_FRAME_HEADER_EN
        , HDR_SYNC
        , HDR_SEQ
`endif
    } state_t;

    state_t         state_q, state_d;
    logic [RW-1:0]  mem_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  count_q, count_d;
    logic           full_q, ovf_q;
    logic [RW-1:0]  shift_q, shift_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic           push, pop, drop;
`ifdef RESULT_SER_FRAME_HEADER_EN
    logic [1:0]     hdr_q, hdr_d;
    logic [7:0]     seq_q, seq_d;
`endif

    // Fullness is judged on the registered count, before any same-cycle pop.
    assign drop    = bus.i_load && (count_q == CW'(DEPTH));
    assign push    = bus.i_load && !drop;
    assign pop     = (state_q == LOAD);
    assign count_d = count_q + CW'(push) - CW'(pop);

    always_ff @(posedge i_clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.i_words;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
            state_q  <= IDLE;
            shift_q  <= '0;
            idx_q    <= '0;
`ifdef RESULT_SER_FRAME_HEADER_EN
            hdr_q    <= '0;
            seq_q    <= '0;
`endif
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q  <= count_d;
            full_q   <= (count_d == CW'(DEPTH));
            if (drop) ovf_q <= 1'b1;
            state_q  <= state_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
`ifdef RESULT_SER_FRAME_HEADER_EN
            hdr_q    <= hdr_d;
            seq_q    <= seq_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
`ifdef RESULT_SER_FRAME_HEADER_EN
        hdr_d   = hdr_q;
        seq_d   = seq_q;
`endif
        unique case (state_q)
            IDLE: if (count_q != '0) state_d = LOAD;
            LOAD: begin
                shift_d = mem_q[rd_ptr_q];
                idx_d   = '0;
`ifdef RESULT_SER_FRAME_HEADER_EN
                hdr_d   = 2'd2;
                state_d = HDR_SYNC;
`else
                state_d = SEND;
`endif
            end
            SEND: state_d = WAIT;
`ifdef RESULT_SER_FRAME_HEADER_EN
            HDR_SYNC: state_d = WAIT;
            HDR_SEQ:  state_d = WAIT;
`endif
            WAIT: begin
`ifdef RESULT_SER_FRAME_HEADER_EN
                // hdr_q counts the header bytes still owed for this row
                if (bus.i_tx_done && hdr_q != 2'd0) begin
                    hdr_d   = hdr_q - 2'd1;
                    state_d = (hdr_q == 2'd2) ? HDR_SEQ : SEND;
                end else
`endif
                if (bus.i_tx_done) begin
                    shift_d = shift_q >> W_DATA;
                    idx_d   = idx_q + IW'(1);
                    if (idx_q == IW'(BYTES - 1)) begin
                        state_d = (count_q != '0) ? LOAD : IDLE;
`ifdef RESULT_SER_FRAME_HEADER_EN
                        seq_d   = seq_q + 8'd1;
`endif
                    end else begin
                        state_d = SEND;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.o_tx_byte = shift_q[W_DATA-1:0];
        bus.o_tx_dv   = (state_q == SEND);
`ifdef RESULT_SER_FRAME_HEADER_EN
        if (hdr_q == 2'd2)      bus.o_tx_byte = W_DATA'(8'hA5);
        else if (hdr_q == 2'd1) bus.o_tx_byte = W_DATA'(seq_q);
        if (state_q == HDR_SYNC || state_q == HDR_SEQ) bus.o_tx_dv = 1'b1;
`endif
    end

    assign bus.o_full     = full_q;
    assign bus.o_overflow = ovf_q;
    assign bus.o_busy     = (state_q != IDLE) || (count_q != '0);
endmodule

// File: tb/tb_result_word_serializer.sv
// Scoreboard bench for result_word_serializer: byte-stream model plus uart_tx responder.
// Honours RESULT_SER_FRAME_HEADER_EN for the expected header bytes.
module tb_result_word_serializer;
    localparam int COL    = 4;
    localparam int W_WORD = 32;
    localparam int W_DATA = 8;
    localparam int DEPTH  = 4;
    localparam int RW     = COL * W_WORD;
    localparam int BYTES  = RW / W_DATA;
`ifdef RESULT_SER_FRAME_HEADER_EN
    localparam int RL = BYTES + 2;
`else
    localparam int RL = BYTES;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    result_word_serializer_if #(
        .COL(COL), .W_WORD(W_WORD), .W_DATA(W_DATA)
    ) bus ();

    result_word_serializer #(
        .COL(COL), .W_WORD(W_WORD), .W_DATA(W_DATA), .DEPTH(DEPTH)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int         compared   = 0;
    int         mismatched = 0;
    logic [7:0] exp_q[$];
    int         dv_t[$];
    int         seen = 0;
    int         cyc  = 0;
    int         seq_m = 0;
    int         dly  = 3;
    bit         hold = 1'b0;
    bit         spur = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Reference: words in index order, each word little-endian.
    task automatic push_row(input logic [RW-1:0] w);
        logic [W_WORD-1:0] word;
`ifdef RESULT_SER_FRAME_HEADER_EN
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'(seq_m));
        seq_m = (seq_m + 1) % 256;
`endif
        for (int k = 0; k < COL; k++) begin
            word = w[k*W_WORD +: W_WORD];
            for (int b = 0; b < W_WORD / W_DATA; b++)
                exp_q.push_back(8'((word >> (8 * b)) & 32'hFF));
        end
    endtask

    function automatic logic [RW-1:0] rrow();
        logic [RW-1:0] r;
        for (int k = 0; k < COL; k++) r[k*W_WORD +: W_WORD] = $urandom;
        return r;
    endfunction

    task automatic issue(input logic [RW-1:0] w, input bit acc);
        @(negedge clk);
        bus.i_load  = 1'b1;
        bus.i_words = w;
        if (acc) push_row(w);
    endtask

    task automatic idle_in();
        @(negedge clk);
        bus.i_load = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int bound);
        int n = 0;
        while ((exp_q.size() != 0 || bus.o_busy) && n < bound) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(n >= bound), 64'd0);
    endtask

    task automatic wait_seen(input string name, input int target);
        int n = 0;
        while (seen < target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(n >= 2000), 64'd0);
    endtask

    // Monitor: every dv pulse pops and compares one expected byte.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (!rst && bus.o_tx_dv) begin
                dv_t.push_back(cyc);
                seen++;
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL extra_byte: got %0h expected none",
                             bus.o_tx_byte);
                end else begin
                    e = exp_q.pop_front();
                    check("byte", 64'(bus.o_tx_byte), 64'(e));
                end
            end
        end
    end

    // uart_tx stand-in: done pulse dly cycles after dv, optional spurious pulses.
    initial begin
        int d;
        bus.i_tx_done = 1'b0;
        @(posedge clk);
        #1;
        forever begin
            if (!rst && bus.o_tx_dv) begin
                d = dly;
                if (spur) bus.i_tx_done = 1'b1;
                @(posedge clk);
                #1;
                bus.i_tx_done = 1'b0;
                while (hold) begin
                    @(posedge clk);
                    #1;
                end
                repeat (d - 1) begin
                    @(posedge clk);
                    #1;
                end
                bus.i_tx_done = 1'b1;
                @(posedge clk);
                #1;
                bus.i_tx_done = 1'b0;
            end else begin
                if (spur && !rst && !bus.o_busy && $urandom_range(0, 3) == 0)
                    bus.i_tx_done = 1'b1;
                @(posedge clk);
                #1;
                bus.i_tx_done = 1'b0;
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [RW-1:0] row;
        logic [7:0]    a1, bad;
        int            mark;

        bus.i_load  = 1'b0;
        bus.i_words = '0;
        repeat (2) @(negedge clk);
        check("rst_dv",   64'(bus.o_tx_dv),     64'd0);
        check("rst_byte", 64'(bus.o_tx_byte),   64'd0);
        check("rst_full", 64'(bus.o_full),      64'd0);
        check("rst_busy", 64'(bus.o_busy),      64'd0);
        check("rst_ovf",  64'(bus.o_overflow),  64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single known row, 3-cycle done latency.
        dly  = 3;
        mark = seen;
        row  = {32'h0F0E0D0C, 32'h0B0A0908, 32'h07060504, 32'h03020100};
        issue(row, 1'b1);
        @(posedge clk);
        #1;
        bus.i_load = 1'b0;
        @(posedge clk);
        #1;
        check("lat_e1_dv", 64'(bus.o_tx_dv), 64'd0);
        @(posedge clk);
        #1;
        check("lat_e2_dv", 64'(bus.o_tx_dv), 64'd1);
        check("busy_run",  64'(bus.o_busy),  64'd1);
        wait_drain("single_drain", 2000);
        check("single_cnt", 64'(seen - mark), 64'(RL));
        check("single_busy", 64'(bus.o_busy), 64'd0);

        // Three back-to-back loads; row boundary gap is dly+2 (no IDLE bubble).
        mark = dv_t.size();
        for (int i = 0; i < 3; i++) issue(rrow(), 1'b1);
        idle_in();
        wait_drain("b2b_drain", 4000);
        check("b2b_cnt", 64'(dv_t.size() - mark), 64'(3 * RL));
        check("b2b_gap1", 64'(dv_t[mark+RL] - dv_t[mark+RL-1]), 64'(dly + 2));
        check("b2b_gap2", 64'(dv_t[mark+2*RL] - dv_t[mark+2*RL-1]),
              64'(dly + 2));
        check("b2b_ovf", 64'(bus.o_overflow), 64'd0);

        // Overflow: row A in flight with done held, then fill FIFO and overrun.
        hold = 1'b1;
        mark = seen;
        row  = rrow();
`ifdef RESULT_SER_FRAME_HEADER_EN
        a1 = 8'hA5;
`else
        a1 = row[7:0];
`endif
        issue(row, 1'b1);
        idle_in();
        wait_seen("ovf_first_dv", mark + 1);
        for (int i = 0; i < 3; i++) issue(rrow(), 1'b1);
        @(posedge clk);
        #1;
        check("full_at3", 64'(bus.o_full), 64'd0);
        issue(rrow(), 1'b1);
        @(posedge clk);
        #1;
        check("full_at4", 64'(bus.o_full),     64'd1);
        check("ovf_at4",  64'(bus.o_overflow), 64'd0);
        issue(rrow(), 1'b0);
        @(posedge clk);
        #1;
        check("ovf_at5",  64'(bus.o_overflow), 64'd1);
        check("full_at5", 64'(bus.o_full),     64'd1);
        idle_in();
        bad = a1;
        repeat (1000) begin
            @(negedge clk);
            if (bus.o_tx_byte !== a1) bad = bus.o_tx_byte;
        end
        check("wait_hold_byte", 64'(bad), 64'(a1));
        check("wait_no_dv", 64'(seen - mark), 64'd1);
        hold = 1'b0;
        wait_drain("ovf_drain", 6000);
        check("ovf_cnt", 64'(seen - mark), 64'(5 * RL));
        check("ovf_sticky", 64'(bus.o_overflow), 64'd1);

        // Mid-row reset after byte 5, then a fresh row restarts at byte 0.
        dly  = 2;
        mark = seen;
        issue(rrow(), 1'b1);
        idle_in();
        wait_seen("rst_mid_wait", mark + 5);
        @(posedge clk);
        #2;
        rst = 1'b1;
        exp_q.delete();
        seq_m = 0;
        #1;
        check("mrst_dv",   64'(bus.o_tx_dv),    64'd0);
        check("mrst_busy", 64'(bus.o_busy),     64'd0);
        check("mrst_full", 64'(bus.o_full),     64'd0);
        check("mrst_ovf",  64'(bus.o_overflow), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        mark = seen;
        issue(rrow(), 1'b1);
        idle_in();
        wait_drain("mrst_drain", 2000);
        check("mrst_cnt", 64'(seen - mark), 64'(RL));

        // Random rows, random done latency, spurious done in IDLE and SEND.
        spur = 1'b1;
        mark = seen;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            dly = $urandom_range(1, 4);
            if (exp_q.size() <= (DEPTH - 1) * RL && $urandom_range(0, 2) != 0)
            begin
                row         = rrow();
                bus.i_load  = 1'b1;
                bus.i_words = row;
                push_row(row);
            end else begin
                bus.i_load = 1'b0;
            end
        end
        idle_in();
        wait_drain("rand_drain", 20000);
        check("rand_ovf", 64'(bus.o_overflow), 64'd0);
        spur = 1'b0;
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end
endmodule
